// File: rtl/pp_colop_if.sv
// Handshake bundle between the column stream reader, pp_colop and the result writer.
// The master modport is the side that feeds beats and drains results.
interface pp_colop_if #(
  parameter int NUM_SIZE = 32,
  parameter int CMD_W    = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [CMD_W-1:0]           cmd;
  logic signed [NUM_SIZE-1:0] in1;
  logic signed [NUM_SIZE-1:0] in2;
  logic                       last;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [NUM_SIZE-1:0] out;
  logic                       sat;
  logic                       err;

  modport master (
    output in_valid, cmd, in1, in2, last, out_ready,
    input  in_ready, out_valid, out, sat, err
  );

  modport slave (
    input  in_valid, cmd, in1, in2, last, out_ready,
    output in_ready, out_valid, out, sat, err
  );
endinterface

// File: rtl/pp_colop.sv
// Fixed-point column-operation unit: element-wise ops and SUM/CNT reductions
// on signed Q-format operands, with saturation and a single output register.
module pp_colop #(
  parameter int NUM_SIZE  = 32,
  parameter int FRAC_BITS = 16,
  parameter int CMD_W     = 4
) (
  input logic      clk,
  input logic      reset,
  pp_colop_if.slave bus
);

  localparam int PW = 2 * NUM_SIZE;

  localparam logic [CMD_W-1:0] OP_NOOP  = CMD_W'(0);
  localparam logic [CMD_W-1:0] OP_ADD   = CMD_W'(1);
  localparam logic [CMD_W-1:0] OP_SUB   = CMD_W'(2);
  localparam logic [CMD_W-1:0] OP_MUL   = CMD_W'(3);
  localparam logic [CMD_W-1:0] OP_MIN   = CMD_W'(4);
  localparam logic [CMD_W-1:0] OP_MAX   = CMD_W'(5);
  localparam logic [CMD_W-1:0] OP_CMPGT = CMD_W'(6);
  localparam logic [CMD_W-1:0] OP_SUM   = CMD_W'(7);
  localparam logic [CMD_W-1:0] OP_CNT   = CMD_W'(8);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam logic signed [NUM_SIZE-1:0] S_MAX  = {1'b0, {(NUM_SIZE-1){1'b1}}};
  localparam logic signed [NUM_SIZE-1:0] S_MIN  = {1'b1, {(NUM_SIZE-1){1'b0}}};
  localparam logic signed [NUM_SIZE-1:0] S_ZERO = '0;
  localparam logic signed [NUM_SIZE-1:0] S_ONE  = NUM_SIZE'(1);

  // Returns {sat, value}: clamps an (N+1)-bit sum/difference to N bits.
  function automatic logic [NUM_SIZE:0] sat_add_w(input logic signed [NUM_SIZE:0] w);
    if (w[NUM_SIZE] != w[NUM_SIZE-1])
      return {1'b1, (w[NUM_SIZE] ? S_MIN : S_MAX)};
    return {1'b0, w[NUM_SIZE-1:0]};
  endfunction

  // Returns {sat, value}: clamps a shifted 2N-bit product to N bits.
  function automatic logic [NUM_SIZE:0] sat_mul_w(input logic signed [PW-1:0] w);
    logic [NUM_SIZE:0] hi;
    hi = w[PW-1:NUM_SIZE-1];
    if ((&hi) || !(|hi))
      return {1'b0, w[NUM_SIZE-1:0]};
    return {1'b1, (w[PW-1] ? S_MIN : S_MAX)};
  endfunction

  logic [0:0]                 state_q, state_d;
  logic [CMD_W-1:0]           op_q, op_d;
  logic signed [NUM_SIZE-1:0] acc_q, acc_d;
  logic                       acc_sat_q, acc_sat_d;

  logic                       vld_p1, vld_d;
  logic signed [NUM_SIZE-1:0] out_p1, out_d;
  logic                       sat_p1, sat_d;
  logic                       err_p1, err_d;

  logic                       in_ready;
  logic                       accept;
  logic signed [NUM_SIZE:0]   add_w, sub_w, acc_w;
  logic signed [PW-1:0]       prod_w, mul_w;
  logic [NUM_SIZE:0]          add_r, sub_r, mul_r, acc_r;
  logic signed [NUM_SIZE-1:0] cnt_inc, red_val;
  logic                       red_sat;

  assign in_ready = !vld_p1 || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign add_w  = $signed({bus.in1[NUM_SIZE-1], bus.in1}) + $signed({bus.in2[NUM_SIZE-1], bus.in2});
  assign sub_w  = $signed({bus.in1[NUM_SIZE-1], bus.in1}) - $signed({bus.in2[NUM_SIZE-1], bus.in2});
  assign prod_w = $signed({{NUM_SIZE{bus.in1[NUM_SIZE-1]}}, bus.in1})
                * $signed({{NUM_SIZE{bus.in2[NUM_SIZE-1]}}, bus.in2});
  assign mul_w  = prod_w >>> FRAC_BITS;
  assign acc_w  = $signed({acc_q[NUM_SIZE-1], acc_q}) + $signed({bus.in1[NUM_SIZE-1], bus.in1});

  assign add_r = sat_add_w(add_w);
  assign sub_r = sat_add_w(sub_w);
  assign mul_r = sat_mul_w(mul_w);
  assign acc_r = sat_add_w(acc_w);

  // CNT shares the accumulator and clamps at MAX without flagging sat.
  assign cnt_inc = (acc_q == S_MAX) ? S_MAX : acc_q + S_ONE;
  assign red_val = (op_q == OP_SUM) ? $signed(acc_r[NUM_SIZE-1:0]) : cnt_inc;
  assign red_sat = (op_q == OP_SUM) && (acc_sat_q || acc_r[NUM_SIZE]);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    vld_d     = vld_p1 && !bus.out_ready;
    out_d     = out_p1;
    sat_d     = sat_p1;
    err_d     = 1'b0;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        case (bus.cmd)
          OP_NOOP: ;
          OP_ADD: begin
            vld_d = 1'b1;
            {sat_d, out_d} = add_r;
          end
          OP_SUB: begin
            vld_d = 1'b1;
            {sat_d, out_d} = sub_r;
          end
          OP_MUL: begin
            vld_d = 1'b1;
            {sat_d, out_d} = mul_r;
          end
          OP_MIN: begin
            vld_d = 1'b1;
            sat_d = 1'b0;
            out_d = (bus.in1 < bus.in2) ? bus.in1 : bus.in2;
          end
          OP_MAX: begin
            vld_d = 1'b1;
            sat_d = 1'b0;
            out_d = (bus.in1 > bus.in2) ? bus.in1 : bus.in2;
          end
          OP_CMPGT: begin
            vld_d = 1'b1;
            sat_d = 1'b0;
            out_d = (bus.in1 > bus.in2) ? S_ONE : S_ZERO;
          end
          OP_SUM, OP_CNT: begin
            if (bus.last) begin
              vld_d = 1'b1;
              sat_d = 1'b0;
              out_d = (bus.cmd == OP_SUM) ? bus.in1 : S_ONE;
            end else begin
              state_d   = ST_ACCUM;
              op_d      = bus.cmd;
              acc_d     = (bus.cmd == OP_SUM) ? bus.in1 : S_ONE;
              acc_sat_d = 1'b0;
            end
          end
          default: err_d = 1'b1;
        endcase
      end else if (bus.cmd == op_q) begin
        if (bus.last) begin
          vld_d     = 1'b1;
          out_d     = red_val;
          sat_d     = red_sat;
          state_d   = ST_IDLE;
          acc_d     = S_ZERO;
          acc_sat_d = 1'b0;
        end else begin
          acc_d     = red_val;
          acc_sat_d = red_sat;
        end
      end else begin
        // Mismatch, NOOP or illegal opcode mid-reduction: drop everything.
        err_d     = 1'b1;
        state_d   = ST_IDLE;
        acc_d     = S_ZERO;
        acc_sat_d = 1'b0;
      end
    end
  end

  // Stage p1: registered result, reduction state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOOP;
      acc_q     <= S_ZERO;
      acc_sat_q <= 1'b0;
      vld_p1    <= 1'b0;
      out_p1    <= S_ZERO;
      sat_p1    <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      vld_p1    <= vld_d;
      out_p1    <= out_d;
      sat_p1    <= sat_d;
      err_p1    <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out       = out_p1;
  assign bus.sat       = sat_p1;
  assign bus.err       = err_p1;

endmodule

// File: tb/tb_pp_colop.sv
// Directed bench for pp_colop with NUM_SIZE=32, FRAC_BITS=16.
module tb_pp_colop;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MIN   = 4'd4;
  localparam logic [3:0] OP_MAX   = 4'd5;
  localparam logic [3:0] OP_CMPGT = 4'd6;
  localparam logic [3:0] OP_SUM   = 4'd7;
  localparam logic [3:0] OP_CNT   = 4'd8;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    logic        s;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  pp_colop_if #(.NUM_SIZE(32), .CMD_W(4)) bus_if ();

  pp_colop #(.NUM_SIZE(32), .FRAC_BITS(16), .CMD_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic l);
    bus_if.in_valid = 1'b1;
    bus_if.cmd      = c;
    bus_if.in1      = a;
    bus_if.in2      = b;
    bus_if.last     = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.in_valid = 1'b0;
    bus_if.last     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus_if.out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_vec++;
    if (bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid);
    end
    n_vec++;
    if (bus_if.out !== 32'h0) begin
      n_bad++; $display("FAIL reset_out: got %h expected 00000000", bus_if.out);
    end
    n_vec++;
    if (bus_if.sat !== 1'b0 || bus_if.err !== 1'b0) begin
      n_bad++; $display("FAIL reset_sat_err: got %b%b expected 00", bus_if.sat, bus_if.err);
    end
    n_vec++;
    if (bus_if.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready);
    end
  endtask

  // Back-to-back element-wise beats: each result visible one cycle after its beat.
  task automatic test_elementwise();
    vec_t v[$];
    v.push_back(vec_t'{OP_ADD,   32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0});
    v.push_back(vec_t'{OP_MUL,   32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0});
    v.push_back(vec_t'{OP_ADD,   32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1});
    v.push_back(vec_t'{OP_SUB,   32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b1});
    v.push_back(vec_t'{OP_SUB,   32'h0001_0000, 32'h0003_0000, 32'hFFFE_0000, 1'b0});
    v.push_back(vec_t'{OP_MUL,   32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_8000, 1'b0});
    v.push_back(vec_t'{OP_MUL,   32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0});
    v.push_back(vec_t'{OP_MUL,   32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1});
    v.push_back(vec_t'{OP_MUL,   32'h8000_0000, 32'h0002_0000, 32'h8000_0000, 1'b1});
    v.push_back(vec_t'{OP_MIN,   32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0});
    v.push_back(vec_t'{OP_MAX,   32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0005, 1'b0});
    v.push_back(vec_t'{OP_CMPGT, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000, 1'b0});
    v.push_back(vec_t'{OP_CMPGT, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].c, v[i].a, v[i].b, 1'b0);
      step();
      n_vec++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out !== v[i].e || bus_if.sat !== v[i].s) begin
        n_bad++;
        $display("FAIL elem[%0d] op%0d: got v=%b out=%h sat=%b expected v=1 out=%h sat=%b",
                 i, v[i].c, bus_if.out_valid, bus_if.out, bus_if.sat, v[i].e, v[i].s);
      end
    end
    drive(OP_NOOP, 32'h1234_5678, 32'h1, 1'b0);
    step();
    idle();
    n_vec++;
    if (bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL noop_no_output: got out_valid=%b expected 0", bus_if.out_valid);
    end
  endtask

  task automatic test_sum();
    logic [31:0] beats [4];
    beats = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
    for (int i = 0; i < 4; i++) begin
      drive(OP_SUM, beats[i], 32'hDEAD_BEEF, i == 3);
      step();
      if (i < 3) begin
        n_vec++;
        if (bus_if.out_valid !== 1'b0) begin
          n_bad++; $display("FAIL sum_partial[%0d]: got out_valid=%b expected 0", i, bus_if.out_valid);
        end
        idle();
        step();
      end
    end
    idle();
    n_vec++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out !== 32'h000A_0000 || bus_if.sat !== 1'b0) begin
      n_bad++;
      $display("FAIL sum_result: got v=%b out=%h sat=%b expected v=1 out=000a0000 sat=0",
               bus_if.out_valid, bus_if.out, bus_if.sat);
    end
    step();
    n_vec++;
    if (bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL sum_single_result: got out_valid=%b expected 0", bus_if.out_valid);
    end
  endtask

  task automatic test_cnt();
    for (int i = 0; i < 5; i++) begin
      drive(OP_CNT, 32'(i * 7), 32'h0, i == 4);
      step();
    end
    idle();
    n_vec++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out !== 32'd5 || bus_if.sat !== 1'b0) begin
      n_bad++;
      $display("FAIL cnt_result: got v=%b out=%h sat=%b expected v=1 out=00000005 sat=0",
               bus_if.out_valid, bus_if.out, bus_if.sat);
    end
    drive(OP_CNT, 32'h0, 32'h0, 1'b1);
    step();
    idle();
    n_vec++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out !== 32'd1) begin
      n_bad++; $display("FAIL cnt_single: got v=%b out=%h expected v=1 out=00000001",
                        bus_if.out_valid, bus_if.out);
    end
    step();
  endtask

  // Saturation inside a reduction is sticky even after the sum comes back in range.
  task automatic test_sum_sat();
    drive(OP_SUM, 32'h7FFF_0000, 32'h0, 1'b0);
    step();
    drive(OP_SUM, 32'h0002_0000, 32'h0, 1'b0);
    step();
    drive(OP_SUM, 32'hFFFF_0000, 32'h0, 1'b1);
    step();
    idle();
    n_vec++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out !== 32'h7FFE_FFFF || bus_if.sat !== 1'b1) begin
      n_bad++;
      $display("FAIL sum_sticky_sat: got v=%b out=%h sat=%b expected v=1 out=7ffeffff sat=1",
               bus_if.out_valid, bus_if.out, bus_if.sat);
    end
    step();
  endtask

  task automatic test_backpressure();
    bus_if.out_ready = 1'b0;
    drive(OP_ADD, 32'h0001_0000, 32'h0002_0000, 1'b0);
    step();
    drive(OP_ADD, 32'h0005_0000, 32'h0006_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out !== 32'h0003_0000 || bus_if.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall[%0d]: got v=%b out=%h rdy=%b expected v=1 out=00030000 rdy=0",
                 i, bus_if.out_valid, bus_if.out, bus_if.in_ready);
      end
      step();
    end
    bus_if.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus_if.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_release_ready: got %b expected 1", bus_if.in_ready);
    end
    step();
    idle();
    n_vec++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out !== 32'h000B_0000) begin
      n_bad++; $display("FAIL stall_next_beat: got v=%b out=%h expected v=1 out=000b0000",
                        bus_if.out_valid, bus_if.out);
    end
    step();
    n_vec++;
    if (bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_drain: got out_valid=%b expected 0", bus_if.out_valid);
    end
  endtask

  task automatic test_illegal();
    drive(4'hF, 32'h1, 32'h2, 1'b0);
    step();
    idle();
    n_vec++;
    if (bus_if.err !== 1'b1 || bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL illegal_err: got err=%b v=%b expected err=1 v=0",
                        bus_if.err, bus_if.out_valid);
    end
    step();
    n_vec++;
    if (bus_if.err !== 1'b0 || bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL illegal_pulse: got err=%b v=%b expected err=0 v=0",
                        bus_if.err, bus_if.out_valid);
    end
  endtask

  task automatic test_mismatch();
    drive(OP_SUM, 32'h0001_0000, 32'h0, 1'b0);
    step();
    drive(OP_SUM, 32'h0002_0000, 32'h0, 1'b0);
    step();
    drive(OP_ADD, 32'h0003_0000, 32'h0001_0000, 1'b0);
    step();
    idle();
    n_vec++;
    if (bus_if.err !== 1'b1 || bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL mismatch_err: got err=%b v=%b expected err=1 v=0",
                        bus_if.err, bus_if.out_valid);
    end
    step();
    n_vec++;
    if (bus_if.err !== 1'b0 || bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL mismatch_pulse: got err=%b v=%b expected err=0 v=0",
                        bus_if.err, bus_if.out_valid);
    end
    drive(OP_SUM, 32'h0005_0000, 32'h0, 1'b1);
    step();
    idle();
    n_vec++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out !== 32'h0005_0000) begin
      n_bad++; $display("FAIL mismatch_restart: got v=%b out=%h expected v=1 out=00050000",
                        bus_if.out_valid, bus_if.out);
    end
    step();
    drive(OP_CNT, 32'h0, 32'h0, 1'b0);
    step();
    drive(OP_NOOP, 32'h0, 32'h0, 1'b0);
    step();
    idle();
    n_vec++;
    if (bus_if.err !== 1'b1 || bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL noop_in_accum: got err=%b v=%b expected err=1 v=0",
                        bus_if.err, bus_if.out_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    drive(OP_SUM, 32'h0001_0000, 32'h0, 1'b0);
    step();
    drive(OP_SUM, 32'h0002_0000, 32'h0, 1'b0);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if (bus_if.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_valid: got %b expected 0", bus_if.out_valid);
    end
    drive(OP_SUM, 32'h0005_0000, 32'h0, 1'b1);
    step();
    idle();
    n_vec++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out !== 32'h0005_0000) begin
      n_bad++; $display("FAIL reset_mid_restart: got v=%b out=%h expected v=1 out=00050000",
                        bus_if.out_valid, bus_if.out);
    end
    step();
    bus_if.out_ready = 1'b0;
    drive(OP_ADD, 32'h0001_0000, 32'h0001_0000, 1'b0);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_if.out_ready = 1'b1;
    n_vec++;
    if (bus_if.out_valid !== 1'b0 || bus_if.out !== 32'h0) begin
      n_bad++; $display("FAIL reset_pending: got v=%b out=%h expected v=0 out=00000000",
                        bus_if.out_valid, bus_if.out);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.cmd       = OP_NOOP;
    bus_if.in1       = '0;
    bus_if.in2       = '0;
    bus_if.last      = 1'b0;
    bus_if.out_ready = 1'b1;
    test_reset();
    test_elementwise();
    test_sum();
    test_cnt();
    test_sum_sat();
    test_backpressure();
    test_illegal();
    test_mismatch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
